// File: rtl/simon_cipher_iterative_decrypt_if.sv
// Control and data bundle between the Simon 32/64 decryptor and its host.
// The host drives loads, start, key and ciphertext; the core returns plaintext and status.
interface simon_cipher_iterative_decrypt_if;
    logic [31:0] cphrtxt;
    logic [63:0] key;
    logic        load_cphrtxt;
    logic        load_key;
    logic        start_decipher;
    logic [31:0] plntxt;
    logic        plntxt_rdy;
    logic        key_rdy;
    logic        busy;

    modport master (
        output cphrtxt, key, load_cphrtxt, load_key, start_decipher,
        input  plntxt, plntxt_rdy, key_rdy, busy
    );

    modport slave (
        input  cphrtxt, key, load_cphrtxt, load_key, start_decipher,
        output plntxt, plntxt_rdy, key_rdy, busy
    );
endinterface

// File: rtl/simon_cipher_iterative_decrypt.sv
// Iterative Simon 32/64 decryptor: expands the key once into a 32-entry round-key file,
// then runs one inverse round per clock using round keys k31 down to k0.
//
// state   | meaning
// IDLE    | waiting; key file may or may not be valid
// KEYEXP  | writing one new round key per cycle (k4..k31)
// DECRYPT | one inverse round per cycle, round counter 31 -> 0
// DONE    | plaintext valid, ready for another start
module simon_cipher_iterative_decrypt (
    input logic                              clk,
    input logic                              rst,
    simon_cipher_iterative_decrypt_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, KEYEXP, DECRYPT, DONE} state_t;

    // Only the first 28 z0 bits are ever consumed by the 4-word key schedule.
    localparam logic [0:27] Z0 = 28'b1111101000100101011000011100;

    function automatic logic [15:0] round_f(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    state_t      state, state_nxt;
    logic        pending, pending_nxt;
    logic [15:0] kf [0:31];
    logic [4:0]  exp_idx;
    logic [4:0]  round;
    logic [31:0] cphr_q;
    logic [15:0] x_q, y_q;
    logic [31:0] plntxt_q;
    logic        key_rdy_q, plntxt_rdy_q;

    logic        key_capture, exp_step, key_done, start_run, rnd_step, finish;
    logic [15:0] t_mix, t_spread, k_new, y_new;
    logic [31:0] run_src;

    always_comb begin
        t_mix    = {kf[exp_idx + 5'd3][2:0], kf[exp_idx + 5'd3][15:3]} ^ kf[exp_idx + 5'd1];
        t_spread = t_mix ^ {t_mix[0], t_mix[15:1]};
        k_new    = ~kf[exp_idx] ^ t_spread ^ {15'd0, Z0[exp_idx]} ^ 16'h0003;
        y_new    = x_q ^ round_f(y_q) ^ kf[round];
        run_src  = bus.load_cphrtxt ? bus.cphrtxt : cphr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        key_capture = 1'b0;
        exp_step    = 1'b0;
        key_done    = 1'b0;
        start_run   = 1'b0;
        rnd_step    = 1'b0;
        finish      = 1'b0;
        if (bus.load_key) begin
            // A key load wins over everything and aborts any run in flight.
            key_capture = 1'b1;
            state_nxt   = KEYEXP;
            pending_nxt = bus.start_decipher;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start_decipher && key_rdy_q) begin
                        start_run = 1'b1;
                        state_nxt = DECRYPT;
                    end
                end
                KEYEXP: begin
                    exp_step = 1'b1;
                    if (bus.start_decipher)
                        pending_nxt = 1'b1;
                    if (exp_idx == 5'd27) begin
                        key_done    = 1'b1;
                        pending_nxt = 1'b0;
                        if (pending || bus.start_decipher) begin
                            start_run = 1'b1;
                            state_nxt = DECRYPT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DECRYPT: begin
                    rnd_step = 1'b1;
                    if (round == 5'd0) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                kf[i] <= 16'd0;
            exp_idx      <= 5'd0;
            round        <= 5'd0;
            cphr_q       <= 32'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            plntxt_q     <= 32'd0;
            key_rdy_q    <= 1'b0;
            plntxt_rdy_q <= 1'b0;
        end else begin
            if (bus.load_cphrtxt)
                cphr_q <= bus.cphrtxt;
            if (key_capture) begin
                kf[0]        <= bus.key[15:0];
                kf[1]        <= bus.key[31:16];
                kf[2]        <= bus.key[47:32];
                kf[3]        <= bus.key[63:48];
                exp_idx      <= 5'd0;
                key_rdy_q    <= 1'b0;
                plntxt_rdy_q <= 1'b0;
            end
            if (exp_step) begin
                kf[exp_idx + 5'd4] <= k_new;
                exp_idx            <= exp_idx + 5'd1;
            end
            if (key_done)
                key_rdy_q <= 1'b1;
            if (start_run) begin
                x_q          <= run_src[31:16];
                y_q          <= run_src[15:0];
                round        <= 5'd31;
                plntxt_rdy_q <= 1'b0;
            end
            if (rnd_step) begin
                x_q   <= y_q;
                y_q   <= y_new;
                round <= round - 5'd1;
            end
            if (finish) begin
                plntxt_q     <= {y_q, y_new};
                plntxt_rdy_q <= 1'b1;
            end
        end
    end

    assign bus.plntxt     = plntxt_q;
    assign bus.plntxt_rdy = plntxt_rdy_q;
    assign bus.key_rdy    = key_rdy_q;
    assign bus.busy       = (state == KEYEXP) || (state == DECRYPT) || pending;
endmodule

// File: tb/tb_simon_cipher_iterative_decrypt.sv
// Bench for the Simon 32/64 decryptor against an array-based Simon model
// (key schedule, encrypt and decrypt computed directly from the cipher definition).
module tb_simon_cipher_iterative_decrypt;
    localparam logic [63:0] PUB_KEY = 64'h1918111009080100;
    localparam logic [31:0] PUB_CT  = 32'hc69be9bb;
    localparam logic [31:0] PUB_PT  = 32'h65656877;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    simon_cipher_iterative_decrypt_if bus();

    simon_cipher_iterative_decrypt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] rk [32];

    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v} << n;
        return d[31:16];
    endfunction

    function automatic logic [15:0] fmod(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    task automatic model_expand(input logic [63:0] k);
        logic [0:61] z;
        logic [15:0] t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++)
            rk[i] = k[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t = rol(rk[i+3], 13) ^ rk[i+1];
            t = t ^ rol(t, 15);
            rk[i+4] = ~rk[i] ^ t ^ {15'd0, z[i]} ^ 16'h0003;
        end
    endtask

    function automatic logic [31:0] model_enc(input logic [31:0] pt);
        logic [15:0] x, y, tmp;
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            tmp = x;
            x   = y ^ fmod(x) ^ rk[r];
            y   = tmp;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] model_dec(input logic [31:0] ct);
        logic [15:0] x, y, tmp;
        x = ct[31:16];
        y = ct[15:0];
        for (int r = 31; r >= 0; r--) begin
            tmp = y;
            y   = x ^ fmod(y) ^ rk[r];
            x   = tmp;
        end
        return {x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic lk, input logic [63:0] k, input logic lc,
                         input logic [31:0] c, input logic st);
        bus.key            = k;
        bus.cphrtxt        = c;
        bus.load_key       = lk;
        bus.load_cphrtxt   = lc;
        bus.start_decipher = st;
        step();
        bus.load_key       = 1'b0;
        bus.load_cphrtxt   = 1'b0;
        bus.start_decipher = 1'b0;
    endtask

    task automatic wait_key(output int n);
        n = 0;
        while (!bus.key_rdy && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!bus.plntxt_rdy && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        bus.key = '0; bus.cphrtxt = '0;
        bus.load_key = 0; bus.load_cphrtxt = 0; bus.start_decipher = 0;
        rst = 1'b0;
        #23;
        n_checks++;
        if ({bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt} !== 35'd0)
            $display("FAIL reset_outputs: got %h want 0", {bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt});
        else n_pass++;
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt} !== 35'd0)
            $display("FAIL after_reset_idle: got %h want 0", {bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt});
        else n_pass++;
    endtask

    task automatic test_start_no_key();
        pulse(1'b0, 64'd0, 1'b1, PUB_CT, 1'b1);
        step();
        step();
        n_checks++;
        if ({bus.busy, bus.plntxt_rdy, bus.plntxt} !== 34'd0)
            $display("FAIL start_without_key: got %h want 0", {bus.busy, bus.plntxt_rdy, bus.plntxt});
        else n_pass++;
    endtask

    task automatic test_published();
        int n;
        model_expand(PUB_KEY);
        pulse(1'b1, PUB_KEY, 1'b0, 32'd0, 1'b0);
        wait_key(n);
        n_checks++;
        if (n !== 28) $display("FAIL keyexp_latency: got %0d want 28", n);
        else n_pass++;
        pulse(1'b0, 64'd0, 1'b1, PUB_CT, 1'b0);
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        wait_rdy(n);
        n_checks++;
        if (n !== 32) $display("FAIL decrypt_latency: got %0d want 32", n);
        else n_pass++;
        n_checks++;
        if (bus.plntxt !== PUB_PT) $display("FAIL published_vector: got %h want %h", bus.plntxt, PUB_PT);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL busy_in_done: got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_early_start();
        int n;
        int busy_low;
        pulse(1'b1, PUB_KEY, 1'b1, PUB_CT, 1'b1);
        n = 0;
        busy_low = 0;
        while (!bus.plntxt_rdy && n < 200) begin
            if (bus.busy !== 1'b1) busy_low++;
            step();
            n++;
        end
        n_checks++;
        if (n !== 60) $display("FAIL early_start_latency: got %0d want 60", n);
        else n_pass++;
        n_checks++;
        if (busy_low !== 0) $display("FAIL early_start_busy: got %0d low cycles want 0", busy_low);
        else n_pass++;
        n_checks++;
        if (bus.plntxt !== PUB_PT) $display("FAIL early_start_result: got %h want %h", bus.plntxt, PUB_PT);
        else n_pass++;
    endtask

    task automatic test_abort();
        int n;
        int rdy_seen;
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 16; i++) step();
        pulse(1'b1, PUB_KEY, 1'b0, 32'd0, 1'b0);
        n = 0;
        rdy_seen = 0;
        while (!bus.key_rdy && n < 100) begin
            if (bus.plntxt_rdy) rdy_seen++;
            step();
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.plntxt_rdy) rdy_seen++;
            step();
        end
        n_checks++;
        if (n !== 28) $display("FAIL abort_key_latency: got %0d want 28", n);
        else n_pass++;
        n_checks++;
        if (rdy_seen !== 0) $display("FAIL abort_no_result: got %0d rdy cycles want 0", rdy_seen);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL abort_idle_busy: got %b want 0", bus.busy);
        else n_pass++;
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        wait_rdy(n);
        n_checks++;
        if (n !== 32 || bus.plntxt !== PUB_PT)
            $display("FAIL abort_restart: got %h after %0d want %h after 32", bus.plntxt, n, PUB_PT);
        else n_pass++;
    endtask

    task automatic test_reload();
        int n;
        logic [31:0] want;
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        pulse(1'b0, 64'd0, 1'b1, 32'h00000000, 1'b0);
        wait_rdy(n);
        n_checks++;
        if (n !== 26 || bus.plntxt !== PUB_PT)
            $display("FAIL reload_inflight: got %h after %0d want %h after 26", bus.plntxt, n, PUB_PT);
        else n_pass++;
        want = model_dec(32'h00000000);
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        wait_rdy(n);
        n_checks++;
        if (n !== 32 || bus.plntxt !== want)
            $display("FAIL reload_next_run: got %h after %0d want %h after 32", bus.plntxt, n, want);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] c;
        for (int i = 0; i < 4; i++) begin
            c = $urandom;
            pulse(1'b0, 64'd0, 1'b1, c, 1'b1);
            wait_rdy(n);
            n_checks++;
            if (n !== 32 || bus.plntxt !== model_dec(c))
                $display("FAIL back_to_back[%0d]: got %h after %0d want %h after 32", i, bus.plntxt, n, model_dec(c));
            else n_pass++;
        end
    endtask

    task automatic test_roundtrip();
        int n;
        logic [63:0] k;
        logic [31:0] pt, ct;
        for (int i = 0; i < 4; i++) begin
            k  = {$urandom, $urandom};
            pt = $urandom;
            model_expand(k);
            ct = model_enc(pt);
            if (i % 2 == 0) begin
                pulse(1'b1, k, 1'b1, ct, 1'b1);
                wait_rdy(n);
                n_checks++;
                if (n !== 60 || bus.plntxt !== pt)
                    $display("FAIL roundtrip_early[%0d]: got %h after %0d want %h after 60", i, bus.plntxt, n, pt);
                else n_pass++;
            end else begin
                pulse(1'b1, k, 1'b0, 32'd0, 1'b0);
                wait_key(n);
                pulse(1'b0, 64'd0, 1'b1, ct, 1'b1);
                wait_rdy(n);
                n_checks++;
                if (n !== 32 || bus.plntxt !== pt)
                    $display("FAIL roundtrip[%0d]: got %h after %0d want %h after 32", i, bus.plntxt, n, pt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_decrypt();
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt} !== 35'd0)
            $display("FAIL reset_mid_decrypt: got %h want 0", {bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt});
        else n_pass++;
        #3;
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_keyexp();
        model_expand(PUB_KEY);
        pulse(1'b1, PUB_KEY, 1'b1, PUB_CT, 1'b1);
        for (int i = 0; i < 10; i++) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt} !== 35'd0)
            $display("FAIL reset_mid_keyexp: got %h want 0", {bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt});
        else n_pass++;
        #3;
        rst = 1'b1;
        step();
        pulse(1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 40; i++) step();
        n_checks++;
        if ({bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt} !== 35'd0)
            $display("FAIL start_after_reset_ignored: got %h want 0", {bus.key_rdy, bus.plntxt_rdy, bus.busy, bus.plntxt});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start_no_key();
        test_published();
        test_early_start();
        test_abort();
        test_reload();
        test_back_to_back();
        test_roundtrip();
        test_reset_mid_decrypt();
        test_reset_mid_keyexp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/simon_cipher_iterative_decrypt.md
# simon_cipher_iterative_decrypt

Iterative Simon 32/64 decryption core, the receive-side counterpart of the team's Simon 32/64 encryption block: it recovers a 32-bit plaintext from a 32-bit ciphertext under a 64-bit key. It expands the key once into a stored 32-entry round-key file, then applies the 32 inverse rounds one per clock with round keys in reverse order (k31 down to k0). It sits behind the same load/start/ready style control used by the encryptor so the two can be paired on the board.

## Interface
- No parameters (block size 32, key size 64, 32 rounds, z0 sequence are fixed).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cphrtxt  input  32  ciphertext; [31:16] = upper word x, [15:0] = lower word y.
- key  input  64  key words k3..k0; [63:48]=k3, [15:0]=k0.
- load_cphrtxt  input  1  capture cphrtxt into the ciphertext register.
- load_key  input  1  capture key and start key expansion.
- start_decipher  input  1  request one decryption of the ciphertext register.
- plntxt  output  32  recovered plaintext, {x, y}; held until next run starts.
- plntxt_rdy  output  1  level; high while plntxt is valid.
- key_rdy  output  1  high when the full round-key file is valid.
- busy  output  1  high in KEYEXP or DECRYPT, or while a start is pending.

## Operation
- States: IDLE, KEYEXP, DECRYPT, DONE. Reset: state IDLE, all registers zero, key_rdy=0, plntxt_rdy=0, plntxt=0, busy=0, pending=0.
- Round function f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2), 16-bit rotates.
- Key expansion, i = 0..27: t = rotr(k[i+3],3) ^ k[i+1]; t = t ^ rotr(t,1); k[i+4] = ~k[i] ^ t ^ z0[i] ^ 16'h0003 (z0[i] in bit 0). z0 index 0 first: 11111010001001010110000111001101111101000100101011000011100110.
- Inverse round with key k[r]: (x, y) -> (y, x ^ f(y) ^ k[r]), r = 31 down to 0.
- load_key (any state): capture k0..k3, key_rdy<=0, plntxt_rdy<=0, enter KEYEXP; any DECRYPT in progress is aborted and pending is cleared unless start_decipher is also high that cycle.
- KEYEXP: one new key word per cycle (k4..k31); after k31 written key_rdy<=1, go to DECRYPT if pending else IDLE.
- load_cphrtxt: captures cphrtxt in any state; never disturbs an in-flight DECRYPT (working x/y registers are separate).
- start_decipher in IDLE or DONE with key_rdy=1: load x/y from ciphertext register (or directly from cphrtxt if load_cphrtxt same cycle), r<=31, plntxt_rdy<=0, enter DECRYPT.
- start_decipher during KEYEXP (or same cycle as load_key): set pending; run begins immediately when expansion completes.
- start_decipher with key_rdy=0 and not in KEYEXP: ignored. During DECRYPT: ignored.
- DECRYPT: one inverse round per cycle; on r=0 round, plntxt<=result, plntxt_rdy<=1, enter DONE.

## Timing
- Key expansion latency: load_key sampled at edge E; key_rdy high after edge E+28.
- Decryption latency: start_decipher sampled at edge S; plntxt/plntxt_rdy valid after edge S+32.
- Start pending during KEYEXP: first round at edge E+29; plntxt_rdy after edge E+60.
- plntxt_rdy falls on the edge that accepts a new start or a load_key; stays low on abort.
- Async reset mid-operation: all outputs return to reset values immediately; key must be reloaded.
- Back-to-back: start accepted in DONE at edge D gives next result after D+32; 33-cycle throughput per block including the DONE cycle minimum.

## Test plan
- Published vector: load_key 64'h1918111009080100, wait key_rdy (28 cycles), load_cphrtxt 32'hc69be9bb, start -> plntxt 32'h65656877, plntxt_rdy exactly 32 edges after start.
- Early start: load_key, load_cphrtxt and start_decipher in the same cycle with above values -> busy high throughout, plntxt 32'h65656877 after 60 edges.
- Abort: mid-DECRYPT (round 15) pulse load_key with same key -> plntxt_rdy stays 0, no result; key_rdy after 28 edges; new start gives 32'h65656877.
- Ciphertext reload mid-run: load_cphrtxt 32'h00000000 during DECRYPT -> current result still 32'h65656877; next start decrypts the new value.
- Start without key after reset -> ignored, busy=0, plntxt_rdy=0, plntxt=0.
- Reset asserted during KEYEXP and during DECRYPT -> key_rdy, plntxt_rdy, busy, plntxt all 0 asynchronously; round-trip with encryptor on random key/plaintext pairs matches.
